// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind an async FIFO: issues credit-limited reads, absorbs the
// one-cycle read latency in a 2-entry buffer, presents a valid/ready stream.
// Optional statistics counters are enabled with `define FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
    parameter int data_width = 8,
    parameter int buf_depth  = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [data_width-1:0] fifo_rdata,
    input  logic                  fifo_valid,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            occupancy,
    output logic                  rd_err
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [15:0]           word_cnt,
    output logic [7:0]            err_cnt
`endif
);

    localparam logic [1:0] full_cnt  = 2'(buf_depth);
    localparam logic [2:0] full_cred = 3'(buf_depth);

    logic [data_width-1:0] buf_q [2];
    logic [data_width-1:0] buf_d [2];
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic                  rd_err_q, rd_err_d;
    logic                  pop_s;
    logic                  capture_s;
    logic                  err_event_s;
    logic [2:0]            credit_s;

    // Read issue, capture/pop bookkeeping and protocol-error detection.
    always_comb begin
        pop_s    = (count_q != 2'd0) & m_ready;
        // credits in use after this cycle's pop; pop implies count_q >= 1, so no underflow
        credit_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        fifo_rd  = ~rst & ~fifo_empty & (credit_s < full_cred);

        // an unsolicited word is kept only if there is space for it
        capture_s   = fifo_valid & (count_q != full_cnt);
        err_event_s = inflight_q ^ fifo_valid;

        buf_d      = buf_q;
        tail_d     = tail_q;
        head_d     = head_q;
        inflight_d = fifo_rd;
        rd_err_d   = rd_err_q | err_event_s;

        if (capture_s) begin
            buf_d[tail_q] = fifo_rdata;
            tail_d        = ~tail_q;
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = ~head_q;
        end else begin
            head_d = head_q;
        end

        count_d = count_q + {1'b0, capture_s} - {1'b0, pop_s};
    end

    // State registers with asynchronous clear.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign m_valid   = (count_q != 2'd0);
    assign m_data    = buf_q[head_q];
    assign occupancy = count_q;
    assign rd_err    = rd_err_q;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Popped-word counter wraps; error-event counter saturates.
    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (pop_s) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end
        if (err_event_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= 16'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule
